// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpu_pkg
// Description : Shared types for the BPU write-port controller: 2-bit
//               likelihood encodings, flush FSM states, counter update
//               function, saturating stat adder and index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bpu_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_FLUSH = 2'd1,
        FL_DONE  = 2'd2
    } flush_state_t;

    // Index width for a table of n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Likelihood counter step; a weak-taken miss falls all the way to SNT,
    // and a taken hit from WNT jumps straight to ST.
    function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        case (cnt)
            CNT_SNT: res = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: res = taken ? CNT_ST  : CNT_SNT;
            CNT_WT:  res = taken ? CNT_ST  : CNT_SNT;
            default: res = taken ? CNT_ST  : CNT_WT;
        endcase
        return res;
    endfunction

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_flush_seq.sv
`default_nettype none
// ============================================================================
// Module      : bpu_flush_seq
// Description : IDLE/FLUSH/DONE sequencer for the whole-table invalidate
//               sweep. idx is the entry being cleared this cycle; sweep_we
//               tells the arbiter a clearing write must be launched now.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_flush_seq
    import bpu_pkg::*;
#(
    parameter  int ENTRY_NUM = 64,
    localparam int IDX_W     = idx_width(ENTRY_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush_req,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] idx,
    output logic             sweep_we
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);

    flush_state_t state;

    // A write is needed on accepting a request, and for every index after the current one.
    assign sweep_we = ((state == FL_IDLE) && flush_req) ||
                      ((state == FL_FLUSH) && (idx != LAST_IDX));

    // Sweep FSM with registered busy/done; stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FL_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (!stall) begin
            case (state)
                FL_IDLE: begin
                    if (flush_req) begin
                        state <= FL_FLUSH;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FL_FLUSH: begin
                    if (idx == LAST_IDX) begin
                        state <= FL_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                FL_DONE: begin
                    state <= FL_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= FL_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpu_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bpu_wr_ctrl
// Description : Single write-port arbiter for the BPU tag/target/counter
//               tables: flush sweep, decode allocation (round-robin pointer),
//               execute counter update with a one-deep replay buffer.
//               Define BPU_STATS_EN to build the saturating stat counters;
//               otherwise stat_* read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_wr_ctrl
    import bpu_pkg::*;
#(
    parameter  int ENTRY_NUM = 64,
    parameter  int XLEN      = 32,
    localparam int IDX_W     = idx_width(ENTRY_NUM)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             alloc_req_i,
    input  logic [XLEN-1:0]  alloc_pc_i,
    input  logic [XLEN-1:0]  alloc_target_i,
    input  logic             alloc_taken_i,
    input  logic             upd_req_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic [1:0]       upd_cnt_i,
    input  logic             upd_taken_i,
    input  logic             flush_req_i,
    output logic             flush_busy_o,
    output logic             flush_done_o,
    output logic             tbl_we_o,
    output logic [IDX_W-1:0] tbl_waddr_o,
    output logic             tbl_wvalid_o,
    output logic             tbl_wtag_we_o,
    output logic [XLEN-1:0]  tbl_wtag_o,
    output logic [XLEN-1:0]  tbl_wtarget_o,
    output logic [1:0]       tbl_wcnt_o,
    output logic [31:0]      stat_alloc_o,
    output logic [31:0]      stat_upd_o,
    output logic [31:0]      stat_drop_o
);

    logic             sweep_we;
    logic [IDX_W-1:0] sweep_idx;
    logic             blocked;

    logic [IDX_W-1:0] alloc_ptr, ptr_nxt;
    logic             buf_valid, buf_valid_nxt;
    logic [IDX_W-1:0] buf_idx, buf_idx_nxt;
    logic [1:0]       buf_cnt, buf_cnt_nxt;

    logic             wr_we, wr_valid, wr_tag_we;
    logic [IDX_W-1:0] wr_addr;
    logic [XLEN-1:0]  wr_tag, wr_target;
    logic [1:0]       wr_cnt, upd_cnt_new;
    logic             inc_alloc, inc_upd;
    logic [1:0]       inc_drop;

    bpu_flush_seq #(.ENTRY_NUM(ENTRY_NUM)) u_flush_seq (
        .clk       (clk_i),
        .rst       (rst_i),
        .stall     (stall_i),
        .flush_req (flush_req_i),
        .busy      (flush_busy_o),
        .done      (flush_done_o),
        .idx       (sweep_idx),
        .sweep_we  (sweep_we)
    );

    // Requests arriving with an accepted flush, or during FLUSH/DONE, lose the port.
    assign blocked = flush_busy_o || flush_done_o || flush_req_i;

    // Arbitration: sweep, then allocation, then replay, then fresh update.
    always_comb begin
        wr_we         = 1'b0;
        wr_addr       = '0;
        wr_valid      = 1'b0;
        wr_tag_we     = 1'b0;
        wr_tag        = '0;
        wr_target     = '0;
        wr_cnt        = CNT_SNT;
        ptr_nxt       = alloc_ptr;
        buf_valid_nxt = buf_valid;
        buf_idx_nxt   = buf_idx;
        buf_cnt_nxt   = buf_cnt;
        inc_alloc     = 1'b0;
        inc_upd       = 1'b0;
        inc_drop      = 2'd0;
        upd_cnt_new   = next_cnt(upd_cnt_i, upd_taken_i);

        if (blocked) begin
            buf_valid_nxt = 1'b0;
            inc_drop      = {1'b0, alloc_req_i} + {1'b0, upd_req_i};
            if (sweep_we) begin
                wr_we     = 1'b1;
                wr_addr   = flush_busy_o ? (sweep_idx + IDX_W'(1)) : '0;
                wr_tag_we = 1'b1;
            end
            if (flush_done_o) begin
                ptr_nxt = '0;
            end
        end else if (alloc_req_i) begin
            wr_we     = 1'b1;
            wr_addr   = alloc_ptr;
            wr_valid  = 1'b1;
            wr_tag_we = 1'b1;
            wr_tag    = alloc_pc_i;
            wr_target = alloc_target_i;
            wr_cnt    = {alloc_taken_i, alloc_taken_i};
            ptr_nxt   = alloc_ptr + IDX_W'(1);
            inc_alloc = 1'b1;
            if (upd_req_i) begin
                // Colliding update parks; any older parked update is lost.
                buf_valid_nxt = 1'b1;
                buf_idx_nxt   = upd_idx_i;
                buf_cnt_nxt   = upd_cnt_new;
                inc_drop      = {1'b0, buf_valid};
            end else if (buf_valid && (buf_idx == alloc_ptr)) begin
                // Entry is being reallocated; its stale counter must not land.
                buf_valid_nxt = 1'b0;
                inc_drop      = 2'd1;
            end
        end else if (buf_valid) begin
            wr_we    = 1'b1;
            wr_addr  = buf_idx;
            wr_valid = 1'b1;
            wr_cnt   = buf_cnt;
            inc_upd  = 1'b1;
            if (upd_req_i) begin
                buf_idx_nxt = upd_idx_i;
                buf_cnt_nxt = upd_cnt_new;
            end else begin
                buf_valid_nxt = 1'b0;
            end
        end else if (upd_req_i) begin
            wr_we    = 1'b1;
            wr_addr  = upd_idx_i;
            wr_valid = 1'b1;
            wr_cnt   = upd_cnt_new;
            inc_upd  = 1'b1;
        end
    end

    // Registered write port, pointer and replay buffer; stall blanks the write and holds state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tbl_we_o      <= 1'b0;
            tbl_waddr_o   <= '0;
            tbl_wvalid_o  <= 1'b0;
            tbl_wtag_we_o <= 1'b0;
            tbl_wtag_o    <= '0;
            tbl_wtarget_o <= '0;
            tbl_wcnt_o    <= CNT_SNT;
            alloc_ptr     <= '0;
            buf_valid     <= 1'b0;
            buf_idx       <= '0;
            buf_cnt       <= CNT_SNT;
        end else if (stall_i) begin
            tbl_we_o <= 1'b0;
        end else begin
            tbl_we_o      <= wr_we;
            tbl_waddr_o   <= wr_addr;
            tbl_wvalid_o  <= wr_valid;
            tbl_wtag_we_o <= wr_tag_we;
            tbl_wtag_o    <= wr_tag;
            tbl_wtarget_o <= wr_target;
            tbl_wcnt_o    <= wr_cnt;
            alloc_ptr     <= ptr_nxt;
            buf_valid     <= buf_valid_nxt;
            buf_idx       <= buf_idx_nxt;
            buf_cnt       <= buf_cnt_nxt;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_alloc, stat_upd, stat_drop;

    // Saturating event counters, advanced only on unstalled cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_alloc <= '0;
            stat_upd   <= '0;
            stat_drop  <= '0;
        end else if (!stall_i) begin
            stat_alloc <= sat_add(stat_alloc, {1'b0, inc_alloc});
            stat_upd   <= sat_add(stat_upd, {1'b0, inc_upd});
            stat_drop  <= sat_add(stat_drop, inc_drop);
        end
    end

    assign stat_alloc_o = stat_alloc;
    assign stat_upd_o   = stat_upd;
    assign stat_drop_o  = stat_drop;
`else
    logic unused_stat_inc;
    assign unused_stat_inc = ^{inc_alloc, inc_upd, inc_drop};
    assign stat_alloc_o    = '0;
    assign stat_upd_o      = '0;
    assign stat_drop_o     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bpu_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpu_wr_ctrl
// Description : Scoreboard bench for bpu_wr_ctrl. Stimulus pushes expected
//               table writes (with the cycle they must appear in); a negedge
//               monitor pops and compares every DUT write.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bpu_wr_ctrl;

    localparam int EN = 64;
    localparam int XL = 32;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst, stall, alloc_req, alloc_taken, upd_req, upd_taken, flush_req;
    logic [XL-1:0] alloc_pc, alloc_target;
    logic [IW-1:0] upd_idx;
    logic [1:0]    upd_cnt;
    logic          flush_busy, flush_done, tbl_we, tbl_wvalid, tbl_wtag_we;
    logic [IW-1:0] tbl_waddr;
    logic [XL-1:0] tbl_wtag, tbl_wtarget;
    logic [1:0]    tbl_wcnt;
    logic [31:0]   stat_alloc, stat_upd, stat_drop;

    typedef struct packed {
        int          cyc;
        logic [5:0]  addr;
        logic        valid;
        logic        tag_we;
        logic [31:0] tag;
        logic [31:0] tgt;
        logic [1:0]  cnt;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  exp_alloc = 0, exp_upd = 0, exp_drop = 0;

    bpu_wr_ctrl #(.ENTRY_NUM(EN), .XLEN(XL)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .alloc_req_i    (alloc_req),
        .alloc_pc_i     (alloc_pc),
        .alloc_target_i (alloc_target),
        .alloc_taken_i  (alloc_taken),
        .upd_req_i      (upd_req),
        .upd_idx_i      (upd_idx),
        .upd_cnt_i      (upd_cnt),
        .upd_taken_i    (upd_taken),
        .flush_req_i    (flush_req),
        .flush_busy_o   (flush_busy),
        .flush_done_o   (flush_done),
        .tbl_we_o       (tbl_we),
        .tbl_waddr_o    (tbl_waddr),
        .tbl_wvalid_o   (tbl_wvalid),
        .tbl_wtag_we_o  (tbl_wtag_we),
        .tbl_wtag_o     (tbl_wtag),
        .tbl_wtarget_o  (tbl_wtarget),
        .tbl_wcnt_o     (tbl_wcnt),
        .stat_alloc_o   (stat_alloc),
        .stat_upd_o     (stat_upd),
        .stat_drop_o    (stat_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stats read as zero when the counters are not built.
    function automatic logic [31:0] se(input int v);
`ifdef BPU_STATS_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", nm, got, req);
        end
    endtask

    task automatic push_wr(input int c, input int a, input logic v, input logic twe,
                           input logic [31:0] tg, input logic [31:0] tt, input logic [1:0] cn);
        wr_t e;
        e.cyc = c; e.addr = IW'(a); e.valid = v; e.tag_we = twe;
        e.tag = tg; e.tgt = tt; e.cnt = cn;
        exp_q.push_back(e);
    endtask

    task automatic push_upd(input int c, input int a, input logic [1:0] cn);
        push_wr(c, a, 1'b1, 1'b0, 32'd0, 32'd0, cn);
        exp_upd++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alloc_req = 1'b0; upd_req = 1'b0; flush_req = 1'b0;
    endtask

    // Drive an allocation sampled at the next edge; hand-given expected index.
    task automatic do_alloc(input int idx, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        alloc_req = 1'b1; alloc_pc = pc; alloc_target = tgt; alloc_taken = tk;
        push_wr(cyc + 1, idx, 1'b1, 1'b1, pc, tgt, {tk, tk});
        exp_alloc++;
    endtask

    task automatic do_upd(input int idx, input logic [1:0] cn, input logic tk);
        upd_req = 1'b1; upd_idx = IW'(idx); upd_cnt = cn; upd_taken = tk;
    endtask

    // Monitor: every DUT write must match the head of the expected queue in cycle and content.
    always @(negedge clk) begin
        wr_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_write cyc=%0d got=none required=addr %0d", exp_q[0].cyc, exp_q[0].addr);
            e = exp_q.pop_front();
        end
        if (tbl_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d got=addr %0d cnt %0d required=no write", cyc, tbl_waddr, tbl_wcnt);
            end else begin
                e = exp_q.pop_front();
                if (tbl_waddr !== e.addr || tbl_wvalid !== e.valid || tbl_wtag_we !== e.tag_we ||
                    tbl_wcnt !== e.cnt ||
                    (e.tag_we && (tbl_wtag !== e.tag || tbl_wtarget !== e.tgt))) begin
                    errors++;
                    $display("FAIL write cyc=%0d got=a%0d v%0d twe%0d tag %h tgt %h cnt %0d required=a%0d v%0d twe%0d tag %h tgt %h cnt %0d",
                             cyc, tbl_waddr, tbl_wvalid, tbl_wtag_we, tbl_wtag, tbl_wtarget, tbl_wcnt,
                             e.addr, e.valid, e.tag_we, e.tag, e.tgt, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; stall = 1'b0; clr();
        alloc_pc = '0; alloc_target = '0; alloc_taken = 1'b0;
        upd_idx = '0; upd_cnt = 2'b00; upd_taken = 1'b0;
        repeat (3) tick();
        chk("rst_we", 32'(tbl_we), 0);
        chk("rst_busy", 32'(flush_busy), 0);
        chk("rst_done", 32'(flush_done), 0);
        chk("rst_waddr", 32'(tbl_waddr), 0);
        chk("rst_stat_alloc", stat_alloc, 0);
        chk("rst_stat_drop", stat_drop, 0);
        rst = 1'b0;
        tick();

        // Three allocations land at 0,1,2 one cycle later
        do_alloc(0, 32'h100, 32'h2000, 1'b1); tick();
        do_alloc(1, 32'h104, 32'h2004, 1'b0); tick();
        do_alloc(2, 32'h108, 32'h2008, 1'b1); tick();
        clr();

        // Counter-only updates, one per table row
        do_upd(2, 2'b01, 1'b1); push_upd(cyc + 1, 2, 2'b11); tick();
        do_upd(5, 2'b11, 1'b0); push_upd(cyc + 1, 5, 2'b10); tick();
        do_upd(7, 2'b00, 1'b0); push_upd(cyc + 1, 7, 2'b00); tick();
        do_upd(9, 2'b10, 1'b0); push_upd(cyc + 1, 9, 2'b00); tick();
        do_upd(10, 2'b00, 1'b1); push_upd(cyc + 1, 10, 2'b01); tick();
        do_upd(11, 2'b01, 1'b0); push_upd(cyc + 1, 11, 2'b00); tick();
        do_upd(12, 2'b10, 1'b1); push_upd(cyc + 1, 12, 2'b11); tick();
        do_upd(13, 2'b11, 1'b1); push_upd(cyc + 1, 13, 2'b11); tick();
        clr(); tick();

        // Collision: alloc at N+1, replayed update at N+2
        k = cyc;
        do_alloc(3, 32'h200, 32'h3000, 1'b0);
        do_upd(1, 2'b10, 1'b1); push_upd(k + 2, 1, 2'b11);
        tick(); clr(); tick(); tick();

        // Buffered update for idx 5 discarded by the allocation of idx 5
        k = cyc;
        do_alloc(4, 32'h210, 32'h3010, 1'b1);
        do_upd(5, 2'b01, 1'b1);
        tick(); clr();
        do_alloc(5, 32'h214, 32'h3014, 1'b0); exp_drop++;
        tick(); clr(); tick();
        chk("drop_after_discard", stat_drop, se(1));

        // Newer colliding update overwrites the parked one
        k = cyc;
        do_alloc(6, 32'h220, 32'h3020, 1'b0);
        do_upd(0, 2'b00, 1'b1);
        tick();
        do_alloc(7, 32'h224, 32'h3024, 1'b1);
        do_upd(1, 2'b11, 1'b0); exp_drop++;
        tick(); clr();
        push_upd(k + 3, 1, 2'b10);
        tick(); tick();

        // Parked update drains while a fresh update takes its place
        k = cyc;
        do_alloc(8, 32'h230, 32'h3030, 1'b1);
        do_upd(2, 2'b01, 1'b0);
        tick(); clr();
        do_upd(3, 2'b00, 1'b1); push_upd(k + 2, 2, 2'b00);
        tick(); clr();
        push_upd(k + 3, 3, 2'b01);
        tick(); tick();
        chk("stat_alloc_mid", stat_alloc, se(exp_alloc));
        chk("stat_upd_mid", stat_upd, se(exp_upd));
        chk("stat_drop_mid", stat_drop, se(exp_drop));

        // Fill the rest of the table; the next allocation wraps to 0
        for (int i = 9; i < EN; i++) begin
            do_alloc(i, 32'h1000 + 32'(i * 4), 32'h8000 + 32'(i), 1'(i));
            tick();
        end
        do_alloc(0, 32'h4000, 32'h5000, 1'b1); tick();
        clr(); tick();

        // Flush sweep with allocs/updates presented during it
        k = cyc;
        flush_req = 1'b1;
        for (int i = 0; i < EN; i++) push_wr(k + 1 + i, i, 1'b0, 1'b1, 32'd0, 32'd0, 2'b00);
        tick(); flush_req = 1'b0;
        for (int j = 1; j <= 66; j++) begin
            chk("flush_busy", 32'(flush_busy), 32'(j <= 64));
            chk("flush_done", 32'(flush_done), 32'(j == 65));
            clr();
            if (j == 10) begin alloc_req = 1'b1; exp_drop++; end
            if (j == 20) begin upd_req = 1'b1; exp_drop++; end
            tick();
        end
        clr();
        do_alloc(0, 32'h600, 32'h7000, 1'b0); tick();
        clr(); tick();

        // Flush with a 5-cycle stall after idx 9; requests during stall are ignored
        k = cyc;
        flush_req = 1'b1;
        for (int i = 0; i < EN; i++)
            push_wr(k + 1 + i + ((i >= 10) ? 5 : 0), i, 1'b0, 1'b1, 32'd0, 32'd0, 2'b00);
        tick(); flush_req = 1'b0;
        for (int j = 1; j <= 71; j++) begin
            chk("stall_busy", 32'(flush_busy), 32'(j <= 69));
            chk("stall_done", 32'(flush_done), 32'(j == 70));
            clr();
            stall = (j >= 10 && j <= 14);
            if (stall) alloc_req = 1'b1;
            tick();
        end
        clr(); stall = 1'b0;
        chk("stat_alloc_pre_rst", stat_alloc, se(exp_alloc));
        chk("stat_upd_pre_rst", stat_upd, se(exp_upd));
        chk("stat_drop_pre_rst", stat_drop, se(exp_drop));

        // Reset in the middle of a sweep
        k = cyc;
        flush_req = 1'b1;
        for (int i = 0; i < 20; i++) push_wr(k + 1 + i, i, 1'b0, 1'b1, 32'd0, 32'd0, 2'b00);
        tick(); flush_req = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(flush_busy), 0);
        chk("midrst_we", 32'(tbl_we), 0);
        chk("midrst_done", 32'(flush_done), 0);
        chk("midrst_stat_alloc", stat_alloc, 0);
        chk("midrst_stat_drop", stat_drop, 0);
        exp_alloc = 0; exp_upd = 0; exp_drop = 0;
        rst = 1'b0;
        tick();
        do_alloc(0, 32'h900, 32'hA00, 1'b1); tick();
        clr(); tick(); tick();
        chk("final_stat_alloc", stat_alloc, se(exp_alloc));
        chk("final_stat_upd", stat_upd, se(exp_upd));
        chk("final_stat_drop", stat_drop, se(exp_drop));
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bpu_wr_ctrl.md
# bpu_wr_ctrl

Write-port controller for the branch prediction unit's target, tag and 2-bit likelihood tables. It arbitrates the single table write port between three requesters: decode-time allocation, execute-time counter update, and a multi-cycle flush sweep (fence.i or debug re-entry). It also owns the round-robin allocation pointer and a one-deep replay buffer for colliding updates. It sits between Decode/Execute and the BPU storage, replacing direct table writes.

## Interface
- ENTRY_NUM, 64, table entries (power of two, ≥4)
- XLEN, 32, address width
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  pipeline stall; freezes all state, suppresses writes
- alloc_req_i  in  1  decode sees an untracked branch/jal
- alloc_pc_i  in  XLEN  tag for new entry
- alloc_target_i  in  XLEN  target for new entry
- alloc_taken_i  in  1  initial direction
- upd_req_i  in  1  execute resolved a tracked branch
- upd_idx_i  in  log2(ENTRY_NUM)  entry index to update
- upd_cnt_i  in  2  current counter of upd_idx_i, read from table
- upd_taken_i  in  1  resolved direction
- flush_req_i  in  1  invalidate whole table
- flush_busy_o  out  1  sweep in progress
- flush_done_o  out  1  one-cycle pulse at sweep end
- tbl_we_o  out  1  table write enable
- tbl_waddr_o  out  log2(ENTRY_NUM)  write index
- tbl_wvalid_o  out  1  valid bit written
- tbl_wtag_we_o  out  1  tag/target fields written (0 = counter-only write)
- tbl_wtag_o  out  XLEN  tag written
- tbl_wtarget_o  out  XLEN  target written
- tbl_wcnt_o  out  2  counter written
- stat_alloc_o, stat_upd_o, stat_drop_o  out  32 each  performance counters

## Operation
- FSM states: IDLE, FLUSH, DONE.
- IDLE→FLUSH on flush_req_i. FLUSH sweeps indices 0…ENTRY_NUM-1, one per unstalled cycle, writing valid=0, cnt=00, tag/target=0.
- FLUSH→DONE after index ENTRY_NUM-1 is written. DONE lasts one cycle: flush_done_o=1, alloc pointer=0. DONE→IDLE.
- flush_req_i is ignored in FLUSH and DONE.
- In FLUSH and DONE, alloc and upd requests are dropped (stat_drop_o increments once per dropped request), and the replay buffer is cleared on entry to FLUSH.
- Priority in IDLE: allocation > replay buffer > new update.
- Allocation writes at index alloc_ptr: valid=1, tag, target, cnt={alloc_taken_i, alloc_taken_i}. alloc_ptr then advances, wrapping ENTRY_NUM-1→0.
- Update computes the next counter:
  - 00: taken→01, not-taken→00
  - 01: taken→11, not-taken→00
  - 10: taken→11, not-taken→00
  - 11: taken→11, not-taken→10
  - Write is counter-only: tbl_wtag_we_o=0, valid=1.
- Collision (alloc and upd in the same cycle): the update's computed counter and index are held in the replay buffer and written on the next cycle with no allocation.
- Buffer occupied and a new colliding update arrives: the newer update overwrites the older; stat_drop_o+1.
- Buffer occupied, no allocation, and a new update arrives: the buffer is written; the new update moves into the buffer.
- Replay is discarded (stat_drop_o+1) if an allocation targets the buffered index before the replay.
- Stats (alloc, update-write, drop) count only unstalled events and saturate at 2^32-1.

## Timing
- Registered outputs: a request sampled at edge N produces its tbl_* write during cycle N+1 (tbl_we_o=1 for that cycle only).
- Flush: request at N, flush_busy_o high from N+1 for ENTRY_NUM cycles (plus any stall cycles); flush_done_o at N+ENTRY_NUM+1.
- stall_i=1: tbl_we_o=0, and FSM, pointer, buffer and stats hold. Requests presented during stall are not sampled.
- Reset (including mid-flush): all outputs 0, state IDLE, alloc_ptr 0, buffer empty, stats 0.

## Configuration
- BPU_STATS_EN defined: the stat_* counters are implemented.
- BPU_STATS_EN undefined: stat_* outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Package bpu_pkg: counter encodings (SNT=00, WNT=01, WT=10, ST=11), FSM state enum, next-counter function, index width derived from ENTRY_NUM.
- Sub-module bpu_flush_seq holds the IDLE/FLUSH/DONE FSM and the sweep index, and exports busy, done, and the current sweep index.
- Arbitration, replay buffer and stats stay in bpu_wr_ctrl.

## Test plan
- Reset, then 3 allocs at PCs 0x100/0x104/0x108 → writes at idx 0,1,2 one cycle later. With ENTRY_NUM=4, a 5th alloc wraps to idx 0.
- Update idx 2, cnt=01, taken → counter-only write at idx 2, cnt=11. cnt=11 not-taken → 10. cnt=00 not-taken → 00.
- Alloc and update (idx 1, cnt 10, taken) in the same cycle → alloc at N+1, cnt 11 at idx 1 at N+2.
- Colliding update buffered for idx 3, then an alloc hits idx 3 → replay discarded, stat_drop_o=1 (with BPU_STATS_EN).
- flush_req_i with ENTRY_NUM=64 → 64 clearing writes idx 0…63, flush_done_o at N+65. Allocs during the sweep are dropped. The next alloc goes to idx 0.
- Assert stall_i for 5 cycles mid-flush → sweep index holds, done is delayed by 5. Assert rst_i mid-flush → IDLE, flush_busy_o=0 next cycle.
